// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scanner.
package seg7_pkg;

  localparam int unsigned SegW = 7;

  // Active-high {g,f,e,d,c,b,a} patterns for hex digits 0..F.
  localparam logic [SegW-1:0] HexSegTable [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic int unsigned idx_width(input int unsigned num_digits);
    return (num_digits > 1) ? $clog2(num_digits) : 1;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-high {g..a} segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0]      nibble_i,
  output logic [SegW-1:0] seg_o
);

  always_comb begin
    seg_o = HexSegTable[nibble_i];
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scanner: dead-time, PWM brightness, leading-zero blanking and
// frame-synchronous double-buffered digit update. All pins are registered.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned SCAN_DIV       = 131072,
  parameter int unsigned DEAD_CYC       = 64,
  parameter int unsigned BRIGHT_W       = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          CS_ACTIVE_LOW  = 1'b1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [4*NUM_DIGITS-1:0] DIGITS_IN,
  input  logic [NUM_DIGITS-1:0]   DP_IN,
  input  logic [NUM_DIGITS-1:0]   DIG_EN,
  input  logic                    LOAD,
  input  logic [BRIGHT_W-1:0]     BRIGHT,
  input  logic                    LZ_SUPPRESS,
  output logic [SegW-1:0]         SEG,
  output logic                    SEG_DP,
  output logic [NUM_DIGITS-1:0]   SEG_CS,
  output logic                    FRAME_START,
  output logic                    LOAD_PENDING
);

  localparam int unsigned SlotW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IdxW  = idx_width(NUM_DIGITS);

  localparam logic [SegW-1:0]       SegOff = {SegW{SEG_ACTIVE_LOW}};
  localparam logic                  DpOff  = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] CsOff  = {NUM_DIGITS{CS_ACTIVE_LOW}};

  logic [SlotW-1:0]        slot_cnt_q, slot_cnt_d;
  logic [IdxW-1:0]         dig_idx_q, dig_idx_d;
  logic [4*NUM_DIGITS-1:0] pend_dig_q, pend_dig_d, disp_dig_q, disp_dig_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
  logic [NUM_DIGITS-1:0]   pend_en_q, pend_en_d, disp_en_q, disp_en_d;
  logic                    load_pending_q, load_pending_d;
  logic                    frame_start_q, frame_start_d;
  logic [SegW-1:0]         seg_q, seg_d;
  logic                    seg_dp_q, seg_dp_d;
  logic [NUM_DIGITS-1:0]   seg_cs_q, seg_cs_d;

  logic                    slot_wrap, boundary;
  logic [3:0]              cur_nib;
  logic                    cur_en, cur_dp, cur_blank;
  logic [NUM_DIGITS-1:0]   cur_sel, lz_blank;
  logic                    lz_run, pwm_on, lit;
  logic [SegW-1:0]         cur_seg;

  seg7_hex_decode u_hex_decode (
    .nibble_i (cur_nib),
    .seg_o    (cur_seg)
  );

  always_comb begin
    slot_wrap  = (slot_cnt_q == SlotW'(SCAN_DIV - 1));
    boundary   = slot_wrap && (dig_idx_q == IdxW'(NUM_DIGITS - 1));
    slot_cnt_d = slot_wrap ? '0 : slot_cnt_q + 1'b1;
    dig_idx_d  = dig_idx_q;
    if (slot_wrap) begin
      dig_idx_d = (dig_idx_q == IdxW'(NUM_DIGITS - 1)) ? '0 : dig_idx_q + 1'b1;
    end
    frame_start_d = boundary;
  end

  // A LOAD landing on the boundary bypasses the pending set.
  always_comb begin
    pend_dig_d     = pend_dig_q;
    pend_dp_d      = pend_dp_q;
    pend_en_d      = pend_en_q;
    disp_dig_d     = disp_dig_q;
    disp_dp_d      = disp_dp_q;
    disp_en_d      = disp_en_q;
    load_pending_d = load_pending_q;
    if (LOAD) begin
      pend_dig_d     = DIGITS_IN;
      pend_dp_d      = DP_IN;
      pend_en_d      = DIG_EN;
      load_pending_d = 1'b1;
    end
    if (boundary) begin
      if (LOAD) begin
        disp_dig_d = DIGITS_IN;
        disp_dp_d  = DP_IN;
        disp_en_d  = DIG_EN;
      end else if (load_pending_q) begin
        disp_dig_d = pend_dig_q;
        disp_dp_d  = pend_dp_q;
        disp_en_d  = pend_en_q;
      end
      load_pending_d = 1'b0;
    end
  end

  always_comb begin
    cur_nib   = 4'h0;
    cur_en    = 1'b0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    cur_sel   = '0;
    lz_blank  = '0;
    lz_run    = LZ_SUPPRESS;
    // Blank from the top digit down until the first nonzero nibble; digit 0 always shows.
    for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
      lz_run      = lz_run && (disp_dig_q[4*i +: 4] == 4'h0);
      lz_blank[i] = lz_run;
    end
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (dig_idx_q == IdxW'(i)) begin
        cur_nib    = disp_dig_q[4*i +: 4];
        cur_en     = disp_en_q[i];
        cur_dp     = disp_dp_q[i];
        cur_blank  = lz_blank[i];
        cur_sel[i] = 1'b1;
      end
    end
    pwm_on = (&BRIGHT) || (slot_cnt_q[BRIGHT_W-1:0] < BRIGHT);
    lit    = (slot_cnt_q >= SlotW'(DEAD_CYC)) && pwm_on && cur_en;

    seg_d    = SegOff;
    seg_dp_d = DpOff;
    seg_cs_d = CsOff;
    if (lit) begin
      seg_cs_d = cur_sel ^ CsOff;
      seg_d    = (cur_blank ? '0 : cur_seg) ^ SegOff;
      seg_dp_d = cur_dp ^ DpOff;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      slot_cnt_q     <= '0;
      dig_idx_q      <= '0;
      pend_dig_q     <= '0;
      pend_dp_q      <= '0;
      pend_en_q      <= '0;
      disp_dig_q     <= '0;
      disp_dp_q      <= '0;
      disp_en_q      <= '0;
      load_pending_q <= 1'b0;
      frame_start_q  <= 1'b0;
      seg_q          <= SegOff;
      seg_dp_q       <= DpOff;
      seg_cs_q       <= CsOff;
    end else begin
      slot_cnt_q     <= slot_cnt_d;
      dig_idx_q      <= dig_idx_d;
      pend_dig_q     <= pend_dig_d;
      pend_dp_q      <= pend_dp_d;
      pend_en_q      <= pend_en_d;
      disp_dig_q     <= disp_dig_d;
      disp_dp_q      <= disp_dp_d;
      disp_en_q      <= disp_en_d;
      load_pending_q <= load_pending_d;
      frame_start_q  <= frame_start_d;
      seg_q          <= seg_d;
      seg_dp_q       <= seg_dp_d;
      seg_cs_q       <= seg_cs_d;
    end
  end

  assign SEG          = seg_q;
  assign SEG_DP       = seg_dp_q;
  assign SEG_CS       = seg_cs_q;
  assign FRAME_START  = frame_start_q;
  assign LOAD_PENDING = load_pending_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: 4 digits, 64-cycle slots, 4-cycle dead time, active-low pins.
module tb_seg7_scan_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] DIGITS_IN = '0;
  logic [3:0]  DP_IN = '0;
  logic [3:0]  DIG_EN = '0;
  logic        LOAD = 1'b0;
  logic [3:0]  BRIGHT = 4'hF;
  logic        LZ_SUPPRESS = 1'b0;
  logic [6:0]  SEG;
  logic        SEG_DP;
  logic [3:0]  SEG_CS;
  logic        FRAME_START;
  logic        LOAD_PENDING;

  int errors = 0;
  int checks = 0;

  seg7_scan_ctrl #(
    .NUM_DIGITS     (4),
    .SCAN_DIV       (64),
    .DEAD_CYC       (4),
    .BRIGHT_W       (4),
    .SEG_ACTIVE_LOW (1'b1),
    .CS_ACTIVE_LOW  (1'b1)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .DIGITS_IN    (DIGITS_IN),
    .DP_IN        (DP_IN),
    .DIG_EN       (DIG_EN),
    .LOAD         (LOAD),
    .BRIGHT       (BRIGHT),
    .LZ_SUPPRESS  (LZ_SUPPRESS),
    .SEG          (SEG),
    .SEG_DP       (SEG_DP),
    .SEG_CS       (SEG_CS),
    .FRAME_START  (FRAME_START),
    .LOAD_PENDING (LOAD_PENDING)
  );

  always #5 CLK = ~CLK;

  task automatic skip(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Leaves the bench at the negedge of the cycle where FRAME_START is high (frame cycle k=0).
  // Pin outputs at cycle k reflect slot (k-1)%64 of digit (k-1)/64.
  task automatic wait_fs();
    int n = 0;
    @(negedge CLK);
    while (FRAME_START !== 1'b1 && n < 600) begin
      @(negedge CLK);
      n++;
    end
    if (FRAME_START !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL frame_start_timeout: no pulse within %0d cycles", n);
    end
  endtask

  task automatic pulse_load(input logic [15:0] dig, input logic [3:0] dp, input logic [3:0] en);
    DIGITS_IN = dig;
    DP_IN     = dp;
    DIG_EN    = en;
    LOAD      = 1'b1;
    @(negedge CLK);
    LOAD      = 1'b0;
  endtask

  task automatic test_reset();
    int bad = 0;
    int gap = 0;
    RST = 1'b1;
    skip(3);
    checks++;
    if ({SEG, SEG_DP, SEG_CS, LOAD_PENDING, FRAME_START} !== {7'h7F, 1'b1, 4'hF, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_pins: got seg=%h dp=%b cs=%h lp=%b fs=%b want 7f 1 f 0 0",
               SEG, SEG_DP, SEG_CS, LOAD_PENDING, FRAME_START);
    end
    RST = 1'b0;
    wait_fs();
    while (gap < 600) begin
      @(negedge CLK);
      gap++;
      if (SEG !== 7'h7F || SEG_DP !== 1'b1 || SEG_CS !== 4'hF || LOAD_PENDING !== 1'b0) bad++;
      if (FRAME_START === 1'b1) break;
    end
    checks++;
    if (gap !== 256) begin
      errors++;
      $display("FAIL frame_period: got %0d want 256", gap);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL dark_after_reset: got %0d non-dark cycles want 0", bad);
    end
  endtask

  task automatic test_display();
    logic [3:0] cs_exp  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [6:0] seg_exp [4] = '{7'h0E, 7'h08, 7'h24, 7'h79};
    BRIGHT = 4'hF;
    wait_fs();
    skip(100);
    pulse_load(16'h12AF, 4'h0, 4'hF);
    checks++;
    if (LOAD_PENDING !== 1'b1) begin
      errors++;
      $display("FAIL pending_set: got %b want 1", LOAD_PENDING);
    end
    wait_fs();
    checks++;
    if (LOAD_PENDING !== 1'b0) begin
      errors++;
      $display("FAIL pending_clear: got %b want 0", LOAD_PENDING);
    end
    skip(2);  // k=2 -> slot 1 of digit 0, inside dead time
    checks++;
    if (SEG_CS !== 4'hF || SEG !== 7'h7F) begin
      errors++;
      $display("FAIL dead_time: got cs=%h seg=%h want f 7f", SEG_CS, SEG);
    end
    skip(28);
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (SEG_CS !== cs_exp[d] || SEG !== seg_exp[d] || SEG_DP !== 1'b1) begin
        errors++;
        $display("FAIL digit%0d: got cs=%h seg=%h dp=%b want %h %h 1",
                 d, SEG_CS, SEG, SEG_DP, cs_exp[d], seg_exp[d]);
      end
      skip(64);
    end
  endtask

  task automatic test_brightness();
    logic [3:0] lvl [3] = '{4'h4, 4'h0, 4'hF};
    int         exp [3] = '{12, 0, 60};
    for (int t = 0; t < 3; t++) begin
      int lit = 0;
      int dead_lit = 0;
      BRIGHT = lvl[t];
      wait_fs();
      for (int k = 1; k <= 64; k++) begin
        @(negedge CLK);
        if (SEG_CS !== 4'hF) begin
          lit++;
          if (k <= 4) dead_lit++;
        end
      end
      checks++;
      if (lit !== exp[t] || dead_lit !== 0) begin
        errors++;
        $display("FAIL bright_%h: got lit=%0d dead_lit=%0d want %0d 0",
                 lvl[t], lit, dead_lit, exp[t]);
      end
    end
    BRIGHT = 4'hF;
  endtask

  task automatic test_lz();
    logic [6:0] s70 [4] = '{7'h40, 7'h78, 7'h7F, 7'h7F};
    logic [6:0] s00 [4] = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
    logic [3:0] cs  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    LZ_SUPPRESS = 1'b1;
    wait_fs();
    skip(20);
    pulse_load(16'h0070, 4'h8, 4'hF);
    wait_fs();
    skip(30);
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (SEG_CS !== cs[d] || SEG !== s70[d] || SEG_DP !== (d != 3)) begin
        errors++;
        $display("FAIL lz_0070_d%0d: got cs=%h seg=%h dp=%b want %h %h %b",
                 d, SEG_CS, SEG, SEG_DP, cs[d], s70[d], d != 3);
      end
      skip(64);
    end
    wait_fs();
    skip(20);
    pulse_load(16'h0000, 4'h0, 4'hF);
    wait_fs();
    skip(30);
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (SEG_CS !== cs[d] || SEG !== s00[d]) begin
        errors++;
        $display("FAIL lz_0000_d%0d: got cs=%h seg=%h want %h %h",
                 d, SEG_CS, SEG, cs[d], s00[d]);
      end
      skip(64);
    end
    LZ_SUPPRESS = 1'b0;
  endtask

  task automatic test_load_timing();
    wait_fs();
    skip(255);  // k=255 is the boundary cycle
    pulse_load(16'h3456, 4'h0, 4'hF);
    checks++;
    if (FRAME_START !== 1'b1 || LOAD_PENDING !== 1'b0) begin
      errors++;
      $display("FAIL boundary_load_lp: got fs=%b lp=%b want 1 0", FRAME_START, LOAD_PENDING);
    end
    skip(10);
    checks++;
    if (SEG_CS !== 4'hE || SEG !== 7'h02 || LOAD_PENDING !== 1'b0) begin
      errors++;
      $display("FAIL boundary_load_show: got cs=%h seg=%h lp=%b want e 02 0",
               SEG_CS, SEG, LOAD_PENDING);
    end
  endtask

  task automatic test_back_to_back();
    wait_fs();
    skip(40);
    pulse_load(16'h1111, 4'h0, 4'hF);
    skip(20);
    pulse_load(16'h2222, 4'h0, 4'hF);
    checks++;
    if (LOAD_PENDING !== 1'b1) begin
      errors++;
      $display("FAIL b2b_pending: got %b want 1", LOAD_PENDING);
    end
    wait_fs();
    skip(30);
    checks++;
    if (SEG_CS !== 4'hE || SEG !== 7'h24) begin
      errors++;
      $display("FAIL b2b_digit0: got cs=%h seg=%h want e 24", SEG_CS, SEG);
    end
    skip(192);
    checks++;
    if (SEG_CS !== 4'h7 || SEG !== 7'h24) begin
      errors++;
      $display("FAIL b2b_digit3: got cs=%h seg=%h want 7 24", SEG_CS, SEG);
    end
  endtask

  task automatic test_reset_midframe();
    int bad = 0;
    wait_fs();
    skip(50);
    pulse_load(16'h9999, 4'hF, 4'hF);
    RST = 1'b1;
    @(negedge CLK);
    checks++;
    if ({SEG, SEG_DP, SEG_CS, LOAD_PENDING, FRAME_START} !== {7'h7F, 1'b1, 4'hF, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midframe_reset: got seg=%h dp=%b cs=%h lp=%b fs=%b want 7f 1 f 0 0",
               SEG, SEG_DP, SEG_CS, LOAD_PENDING, FRAME_START);
    end
    RST = 1'b0;
    for (int k = 0; k < 600; k++) begin
      @(negedge CLK);
      if (SEG !== 7'h7F || SEG_DP !== 1'b1 || SEG_CS !== 4'hF || LOAD_PENDING !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL stale_after_reset: got %0d non-dark cycles want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_display();
    test_brightness();
    test_lz();
    test_load_timing();
    test_back_to_back();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Parametrised multiplexed 7-segment scanner for 1–8 common-cathode/anode digits.
- Scans one digit per slot and hex-decodes each digit's nibble.
- Adds a dead-time gap against ghosting, PWM brightness, leading-zero suppression and frame-synchronous double-buffered update.
- Sits between the Nios/PWM control logic and the board SEG/CS pins.

Parameters:
- NUM_DIGITS, 4, number of scanned digits (1..8).
- SCAN_DIV, 131072, clock cycles per digit slot. Must satisfy SCAN_DIV >= DEAD_CYC + 2**BRIGHT_W.
- DEAD_CYC, 64, cycles at the start of each slot with every digit dark.
- BRIGHT_W, 4, brightness control width.
- SEG_ACTIVE_LOW, 1, 1 means segment/DP pins are driven low when lit.
- CS_ACTIVE_LOW, 1, 1 means digit-select pins are driven low when selected.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, synchronous, active-high.
- DIGITS_IN  in  4*NUM_DIGITS  hex nibbles; nibble i is digit i, digit 0 is least significant.
- DP_IN  in  NUM_DIGITS  decimal point per digit.
- DIG_EN  in  NUM_DIGITS  per-digit enable; 0 means the digit is fully dark.
- LOAD  in  1  one-cycle strobe that captures DIGITS_IN, DP_IN and DIG_EN.
- BRIGHT  in  BRIGHT_W  brightness, sampled live.
- LZ_SUPPRESS  in  1  enables leading-zero blanking, sampled live.
- SEG  out  7  segments {g,f,e,d,c,b,a}.
- SEG_DP  out  1  decimal point.
- SEG_CS  out  NUM_DIGITS  digit selects.
- FRAME_START  out  1  one-cycle pulse at each frame boundary.
- LOAD_PENDING  out  1  captured data is waiting for the next frame boundary.

Behaviour:
- Counters
  - slot_cnt runs 0..SCAN_DIV-1. When it wraps, dig_idx advances 0..NUM_DIGITS-1 and wraps to 0.
  - Frame boundary = the cycle in which slot_cnt==SCAN_DIV-1 and dig_idx==NUM_DIGITS-1.
- Registers
  - Pending set and display set each hold digits, DP and enable.
  - LOAD copies the inputs into the pending set and sets LOAD_PENDING.
  - LOAD while already pending overwrites the pending set; last LOAD wins.
  - At the frame boundary, if pending, the pending set copies to the display set and LOAD_PENDING clears.
  - LOAD in the boundary cycle itself: the LOAD data goes straight into the display set and LOAD_PENDING ends at 0.
- FRAME_START
  - Registered; high in the cycle after the boundary, together with dig_idx==0 and slot_cnt==0.
- Lit condition, for the current digit d:
  - slot_cnt >= DEAD_CYC, and
  - PWM on, and
  - display DIG_EN[d]==1.
  - PWM on means slot_cnt[BRIGHT_W-1:0] < BRIGHT. BRIGHT all-ones forces PWM on.
  - BRIGHT==0 means the digit is dark.
- When lit: SEG_CS[d] is at its active level and every other CS is inactive. When not lit: all CS inactive, SEG and SEG_DP at their off level.
- Decode, active-high form {g..a}:
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
  - Inverted when SEG_ACTIVE_LOW=1.
- Leading-zero suppression
  - When LZ_SUPPRESS=1, zero nibbles are blanked from digit NUM_DIGITS-1 downward until the first nonzero nibble.
  - Digit 0 is never suppressed.
  - A suppressed digit has SEG off but SEG_DP still follows DP_IN, and its CS still scans.
- Latency: all pin outputs are registered, one cycle after the counter state that selects them. No combinational path from inputs to pins.
- Reset state, during and after RST:
  - slot_cnt=0, dig_idx=0; pending and display sets all zero, so the display is dark until the first LOAD.
  - LOAD_PENDING=0, FRAME_START=0.
  - SEG, SEG_DP and SEG_CS all at their off/inactive level.
  - Reset mid-frame discards any pending load.

Decomposition:
- Package seg7_pkg holds:
  - the 16-entry hex segment table constant,
  - a localparam for the segment width (7),
  - a function computing the index width from NUM_DIGITS.
- One sub-module, seg7_hex_decode: combinational nibble to {g..a}, active-high.
- Polarity inversion happens in the top block.

Test Plan:
Common setup: NUM_DIGITS=4, SCAN_DIV=64, DEAD_CYC=4, BRIGHT_W=4, active-low pins.
1. Hold RST 3 cycles, then release → SEG=7F, SEG_DP=1, SEG_CS=F and LOAD_PENDING=0 throughout; FRAME_START pulses every 256 cycles.
2. LOAD mid-frame with DIGITS_IN=12AF, DIG_EN=F, BRIGHT=F → LOAD_PENDING=1 until the boundary. Next frame shows:
   - slot0: CS=E, SEG=0E
   - slot1: CS=D, SEG=08
   - slot2: CS=B, SEG=24
   - slot3: CS=7, SEG=79
3. Brightness, counting lit cycles per slot → BRIGHT=4 gives 12, BRIGHT=0 gives 0, BRIGHT=F gives 60. The first 4 cycles of every slot are always dark.
4. LZ_SUPPRESS=1:
   - DIGITS_IN=0070 → digits 3 and 2 have SEG=7F, digit1 shows 78, digit0 shows 40.
   - DIGITS_IN=0000 → only digit0 lit, showing 40.
5. Load timing:
   - LOAD asserted exactly in the boundary cycle → new value shows in slot0 of the next frame and LOAD_PENDING stays 0.
   - Two LOADs in one frame (1111 then 2222) → only 2222 is displayed.
6. Assert RST mid-frame while LOAD_PENDING=1 → next cycle all pins inactive and LOAD_PENDING=0. After release the display stays dark with no stale data.
